// File: rtl/mem_access_unit_if.sv
// Request/acknowledge memory bus between the MEM-stage access unit and RAM/cache.
interface mem_access_unit_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i, bus_err_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage load/store engine: lane alignment, LL/SC, bus timeout.
// Define MEM_UNALIGNED_TRAP_EN to raise AdEL/AdES on misaligned accesses.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        exc_o,
    output logic [4:0]  exc_code_o,
    mem_access_unit_if.master bus
);
    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  sh_q, sh_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q, exc_d;
    logic [4:0]  code_q, code_d;
    logic        ll_q, ll_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        valid_op, is_store, is_half, is_word, mis_trap, tmo;
    logic [1:0]  off, szm1, sh_c;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, ld_val;
    logic [15:0] ld_h;
    logic [7:0]  ld_b;

    // sh_c is the lane's byte distance from bit 0 of the bus word
    always_comb begin
        valid_op = op_i <= OP_SC;
        is_store = op_i inside {OP_SB, OP_SH, OP_SW, OP_SC};
        is_half  = op_i inside {OP_LH, OP_LHU, OP_SH};
        is_word  = op_i inside {OP_LW, OP_SW, OP_LL, OP_SC};
`ifdef MEM_UNALIGNED_TRAP_EN
        mis_trap = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
        off      = addr_i[1:0];
`else
        mis_trap = 1'b0;
        off      = is_word ? 2'b00 : is_half ? {addr_i[1], 1'b0} : addr_i[1:0];
`endif
        szm1    = {is_word, is_word | is_half};
        sh_c    = BIG_ENDIAN ? (2'd3 - szm1 - off) : off;
        sel_c   = {is_word, is_word, is_word | is_half, 1'b1} << sh_c;
        wdata_c = is_word ? wdata_i :
                  is_half ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    end

    always_comb begin
        ld_h = 16'(bus.bus_rdata_i >> {sh_q, 3'b000});
        ld_b = ld_h[7:0];
        unique case (op_q)
            OP_LB:               ld_val = {{24{ld_b[7]}}, ld_b};
            OP_LBU:              ld_val = {24'd0, ld_b};
            OP_LH:               ld_val = {{16{ld_h[15]}}, ld_h};
            OP_LHU:              ld_val = {16'd0, ld_h};
            OP_SC:               ld_val = 32'd1;
            OP_SB, OP_SH, OP_SW: ld_val = rdata_q;
            default:             ld_val = bus.bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sh_d    = sh_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        code_d  = code_q;
        ll_d    = ll_q;
        cnt_d   = cnt_q;
        tmo     = cnt_q == CNT_LAST;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_i && valid_op && !flush_i) begin
                    op_d   = op_i;
                    exc_d  = 1'b0;
                    code_d = 5'd0;
                    if (mis_trap) begin
                        exc_d   = 1'b1;
                        code_d  = is_store ? 5'd5 : 5'd4;
                        state_d = DONE;
                    end else if (op_i == OP_SC && !ll_q) begin
                        rdata_d = 32'd0;
                        state_d = DONE;
                    end else begin
                        addr_d  = {addr_i[31:2], 2'b00};
                        sel_d   = sel_c;
                        wdata_d = wdata_c;
                        we_d    = is_store;
                        sh_d    = sh_c;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (bus.bus_ack_i || tmo) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        if (!bus.bus_ack_i || bus.bus_err_i) begin
                            exc_d  = 1'b1;
                            code_d = 5'd7;
                        end else begin
                            rdata_d = ld_val;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (flush_i) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.bus_ack_i || tmo) state_d = IDLE;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            DONE: begin
                state_d = IDLE;
                if (!exc_q && op_q == OP_LL) ll_d = 1'b1;
                if (!exc_q && op_q == OP_SC) ll_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) ll_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            sh_q    <= 2'd0;
            rdata_q <= 32'd0;
            exc_q   <= 1'b0;
            code_q  <= 5'd0;
            ll_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            code_q  <= code_d;
            ll_q    <= ll_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_o = ~rst & ((state_q == IDLE && req_i && valid_op && !flush_i)
                             || state_q == BUS || state_q == DRAIN);
    assign done_o     = ~rst & (state_q == DONE);
    assign exc_o      = done_o & exc_q;
    assign exc_code_o = exc_o ? code_q : 5'd0;
    assign rdata_o    = rdata_q;

    assign bus.bus_req_o   = ~rst & (state_q == BUS || state_q == DRAIN);
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (big-endian, TIMEOUT=8).
// Expectations adapt to MEM_UNALIGNED_TRAP_EN when it is defined.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, flush_i;
    logic [3:0]  op_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, exc_o;
    logic [31:0] rdata_o;
    logic [4:0]  exc_code_o;

    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.BIG_ENDIAN(1'b1), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .exc_o(exc_o), .exc_code_o(exc_code_o), .bus(bus)
    );

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] rdata;
        logic        chk_rd;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } bexp_t;

    resp_t rq[$];
    bexp_t bq[$];
    int checks = 0;
    int errors = 0;

    int          s_lat = 1;
    logic [31:0] s_rdata = 32'd0;
    logic        s_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_resp(input logic exc, input logic [4:0] code,
                            input logic [31:0] rd, input logic c);
        resp_t r;
        r.exc = exc; r.code = code; r.rdata = rd; r.chk_rd = c;
        rq.push_back(r);
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic [3:0] s, input logic we,
                           input logic [31:0] wd, input int len);
        bexp_t b;
        b.addr = a; b.sel = s; b.we = we; b.wdata = wd; b.len = len;
        bq.push_back(b);
    endtask

    task automatic slave_cfg(input int lat, input logic [31:0] rd, input logic err);
        s_lat = lat; s_rdata = rd; s_err = err;
    endtask

    // response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done with exc=%b rdata=%h", exc_o, rdata_o);
                end else begin
                    r = rq.pop_front();
                    chk("exc", 32'(exc_o), 32'(r.exc));
                    chk("exc_code", 32'(exc_code_o), 32'(r.code));
                    if (r.chk_rd) chk("rdata", rdata_o, r.rdata);
                    chk("stall_in_done", 32'(stall_o), 32'd0);
                end
            end
        end
    end

    // bus slave with per-transaction latency; checks each request it sees
    initial begin
        bexp_t cur;
        bit in_txn = 0;
        bit have = 0;
        int cyc = 0;
        bus.bus_ack_i = 1'b0; bus.bus_err_i = 1'b0; bus.bus_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.bus_req_o === 1'b1) begin
                if (!in_txn) begin
                    in_txn = 1; cyc = 0;
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_bus_req: got addr %h expected no request", bus.bus_addr_o);
                    end else begin
                        cur = bq.pop_front(); have = 1;
                        chk("bus_addr", bus.bus_addr_o, cur.addr);
                        chk("bus_sel", 32'(bus.bus_sel_o), 32'(cur.sel));
                        chk("bus_we", 32'(bus.bus_we_o), 32'(cur.we));
                        if (cur.we) chk("bus_wdata", bus.bus_wdata_o, cur.wdata);
                    end
                end
                cyc++;
                if (s_lat > 0 && cyc == s_lat) begin
                    bus.bus_ack_i = 1'b1; bus.bus_rdata_i = s_rdata; bus.bus_err_i = s_err;
                end else begin
                    bus.bus_ack_i = 1'b0; bus.bus_err_i = 1'b0;
                end
            end else begin
                bus.bus_ack_i = 1'b0; bus.bus_err_i = 1'b0;
                if (in_txn) begin
                    in_txn = 0;
                    if (have && cur.len > 0) chk("bus_req_len", 32'(cyc), 32'(cur.len));
                    have = 0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                         input int fl, output int nst);
        int k;
        @(negedge clk);
        req_i = 1'b1; op_i = op; addr_i = a; wdata_i = w;
        #1 nst = int'(stall_o);
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            req_i = 1'b0;
            flush_i = (k == fl);
            #1;
            if (!stall_o) break;
            if (k > 60) begin
                checks++; errors++;
                $display("FAIL wait_budget: stall still high after %0d cycles", k);
                break;
            end
            nst++;
        end
        flush_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; op_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_bus_req", 32'(bus.bus_req_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_exc", {26'd0, exc_o, exc_code_o}, 32'd0);
        rst = 1'b0;

        slave_cfg(2, 32'h1122_33F0, 1'b0);
        exp_bus(32'h1000, 4'b0001, 1'b0, 32'd0, 2);
        exp_resp(1'b0, 5'd0, 32'hFFFF_FFF0, 1'b1);
        issue(4'd0, 32'h1003, 32'd0, 0, n);
        chk("lb_stall_cycles", 32'(n), 32'd3);

        slave_cfg(1, 32'h8011_2233, 1'b0);
        exp_bus(32'h1000, 4'b1000, 1'b0, 32'd0, 1);
        exp_resp(1'b0, 5'd0, 32'h0000_0080, 1'b1);
        issue(4'd1, 32'h1000, 32'd0, 0, n);

        slave_cfg(1, 32'h8001_FFFF, 1'b0);
        exp_bus(32'h1000, 4'b1100, 1'b0, 32'd0, 1);
        exp_resp(1'b0, 5'd0, 32'hFFFF_8001, 1'b1);
        issue(4'd2, 32'h1000, 32'd0, 0, n);

        slave_cfg(1, 32'h8001_F00D, 1'b0);
        exp_bus(32'h1000, 4'b0011, 1'b0, 32'd0, 1);
        exp_resp(1'b0, 5'd0, 32'h0000_F00D, 1'b1);
        issue(4'd3, 32'h1002, 32'd0, 0, n);
        chk("lhu_stall_cycles", 32'(n), 32'd2);

        slave_cfg(1, 32'd0, 1'b0);
        exp_bus(32'h2000, 4'b0011, 1'b1, 32'h1234_1234, 1);
        exp_resp(1'b0, 5'd0, 32'h0000_F00D, 1'b1);
        issue(4'd6, 32'h2002, 32'hAAAA_1234, 0, n);

        exp_bus(32'h2000, 4'b0100, 1'b1, 32'hA5A5_A5A5, 1);
        exp_resp(1'b0, 5'd0, 32'h0000_F00D, 1'b1);
        issue(4'd5, 32'h2001, 32'h0000_00A5, 0, n);

        slave_cfg(3, 32'd0, 1'b0);
        exp_bus(32'h2004, 4'b1111, 1'b1, 32'hDEAD_BEEF, 3);
        exp_resp(1'b0, 5'd0, 32'h0000_F00D, 1'b1);
        issue(4'd7, 32'h2004, 32'hDEAD_BEEF, 0, n);

        slave_cfg(1, 32'hCAFE_F00D, 1'b0);
`ifdef MEM_UNALIGNED_TRAP_EN
        exp_resp(1'b1, 5'd4, 32'd0, 1'b0);
        issue(4'd4, 32'h3001, 32'd0, 0, n);
        exp_resp(1'b1, 5'd5, 32'd0, 1'b0);
        issue(4'd7, 32'h3002, 32'h0BAD_0BAD, 0, n);
        chk("misaligned_stall", 32'(n), 32'd1);
`else
        exp_bus(32'h3000, 4'b1111, 1'b0, 32'd0, 1);
        exp_resp(1'b0, 5'd0, 32'hCAFE_F00D, 1'b1);
        issue(4'd4, 32'h3001, 32'd0, 0, n);
        exp_bus(32'h3000, 4'b1111, 1'b1, 32'h0BAD_0BAD, 1);
        exp_resp(1'b0, 5'd0, 32'hCAFE_F00D, 1'b1);
        issue(4'd7, 32'h3002, 32'h0BAD_0BAD, 0, n);
`endif

        slave_cfg(1, 32'h1234_5678, 1'b0);
        exp_bus(32'h40, 4'b1111, 1'b0, 32'd0, 1);
        exp_resp(1'b0, 5'd0, 32'h1234_5678, 1'b1);
        issue(4'd8, 32'h40, 32'd0, 0, n);

        exp_bus(32'h40, 4'b1111, 1'b1, 32'h55, 1);
        exp_resp(1'b0, 5'd0, 32'd1, 1'b1);
        issue(4'd9, 32'h40, 32'h55, 0, n);

        exp_resp(1'b0, 5'd0, 32'd0, 1'b1);
        issue(4'd9, 32'h40, 32'h55, 0, n);
        chk("sc_fail_stall", 32'(n), 32'd1);

        slave_cfg(0, 32'd0, 1'b0);
        exp_bus(32'h50, 4'b1111, 1'b0, 32'd0, 8);
        exp_resp(1'b1, 5'd7, 32'd0, 1'b0);
        issue(4'd4, 32'h50, 32'd0, 0, n);
        chk("timeout_stall", 32'(n), 32'd9);

        slave_cfg(1, 32'hFFFF_FFFF, 1'b1);
        exp_bus(32'h54, 4'b1111, 1'b0, 32'd0, 1);
        exp_resp(1'b1, 5'd7, 32'd0, 1'b0);
        issue(4'd4, 32'h54, 32'd0, 0, n);

        issue(4'd12, 32'h58, 32'd0, 0, n);
        chk("invalid_op_stall", 32'(n), 32'd0);

        @(negedge clk);
        req_i = 1'b1; op_i = 4'd4; addr_i = 32'h5C; flush_i = 1'b1;
        #1 chk("flush_idle_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        req_i = 1'b0; flush_i = 1'b0;
        #1 chk("flush_idle_bus_req", 32'(bus.bus_req_o), 32'd0);

        slave_cfg(1, 32'hA5A5_A5A5, 1'b0);
        exp_bus(32'h60, 4'b1111, 1'b0, 32'd0, 1);
        exp_resp(1'b0, 5'd0, 32'hA5A5_A5A5, 1'b1);
        issue(4'd8, 32'h60, 32'd0, 0, n);

        slave_cfg(4, 32'h7777_7777, 1'b0);
        exp_bus(32'h64, 4'b1111, 1'b0, 32'd0, 4);
        issue(4'd4, 32'h64, 32'd0, 1, n);
        chk("drain_stall_cycles", 32'(n), 32'd5);
        chk("drain_rdata_kept", rdata_o, 32'hA5A5_A5A5);

        exp_resp(1'b0, 5'd0, 32'd0, 1'b1);
        issue(4'd9, 32'h60, 32'h99, 0, n);

        slave_cfg(0, 32'd0, 1'b0);
        exp_bus(32'h70, 4'b1111, 1'b0, 32'd0, 0);
        @(negedge clk);
        req_i = 1'b1; op_i = 4'd4; addr_i = 32'h70;
        @(negedge clk);
        req_i = 1'b0;
        #1 chk("pre_rst_bus_req", 32'(bus.bus_req_o), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_drops_bus_req", 32'(bus.bus_req_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_stall", 32'(stall_o), 32'd0);
        chk("post_rst_bus_req", 32'(bus.bus_req_o), 32'd0);

        repeat (4) @(negedge clk);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("bus_queue_empty", 32'(bq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
